// File: rtl/fp_mult_arbiter.sv
// Round-robin arbiter that shares one single-precision multiplier among NUM_REQ requesters.
// Optional FP_ARB_STATS_EN adds op_count/exc_count handshake statistics ports.
module fp_multiplicator (
  input  logic [31:0] a,
  input  logic [31:0] b,
  output logic [31:0] p,
  output logic        ovf,
  output logic        unf
);
  logic               w_s;
  logic               w_a_zero;
  logic               w_b_zero;
  logic               w_a_spec;
  logic               w_b_spec;
  logic               w_nan;
  logic [47:0]        w_prod;
  logic [22:0]        w_m;
  logic [22:0]        w_mr;
  logic               w_c;
  logic               w_g;
  logic               w_st;
  logic               w_rnd;
  logic signed [10:0] w_e;
  logic signed [10:0] w_e2;

  assign w_s      = a[31] ^ b[31];
  assign w_a_zero = (a[30:23] == 8'h00);
  assign w_b_zero = (b[30:23] == 8'h00);
  assign w_a_spec = (a[30:23] == 8'hFF);
  assign w_b_spec = (b[30:23] == 8'hFF);
  assign w_prod   = {1'b1, a[22:0]} * {1'b1, b[22:0]};
  assign w_e      = $signed({3'b000, a[30:23]})
                  + $signed({3'b000, b[30:23]})
                  - 11'sd127;

  // NaN operands and inf*0 produce the canonical quiet NaN
  assign w_nan = (w_a_spec && (a[22:0] != 23'd0))
              || (w_b_spec && (b[22:0] != 23'd0))
              || (w_a_spec && w_b_zero)
              || (w_b_spec && w_a_zero);

  always_comb begin
    w_m  = w_prod[45:23];
    w_g  = w_prod[22];
    w_st = |w_prod[21:0];
    w_e2 = w_e;
    if (w_prod[47]) begin
      w_m  = w_prod[46:24];
      w_g  = w_prod[23];
      w_st = |w_prod[22:0];
      w_e2 = w_e + 11'sd1;
    end
    w_rnd = w_g & (w_st | w_m[0]);
    {w_c, w_mr} = {1'b0, w_m} + {23'd0, w_rnd};
    if (w_c) w_e2 = w_e2 + 11'sd1;
  end

  always_comb begin
    p   = {w_s, w_e2[7:0], w_mr};
    ovf = 1'b0;
    unf = 1'b0;
    if (w_nan) begin
      p = 32'h7FC0_0000;
    end else if (w_a_spec || w_b_spec) begin
      p = {w_s, 8'hFF, 23'd0};
    end else if (w_a_zero || w_b_zero) begin
      p = {w_s, 31'd0};
    end else if (w_e2 > 11'sd254) begin
      p   = {w_s, 8'hFF, 23'd0};
      ovf = 1'b1;
    end else if (w_e2 < 11'sd1) begin
      p   = {w_s, 31'd0};
      unf = 1'b1;
    end
  end
endmodule

module fp_mult_arbiter #(
  parameter int NUM_REQ     = 4,
  parameter int CALC_CYCLES = 1,
  localparam int ID_W  = (NUM_REQ > 1) ? $clog2(NUM_REQ) : 1,
  localparam int CNT_W = (CALC_CYCLES > 1) ? $clog2(CALC_CYCLES) : 1
) (
  input  logic                  clk,
  input  logic                  reset,
  input  logic [NUM_REQ-1:0]    req_valid,
  output logic [NUM_REQ-1:0]    req_ready,
  input  logic [NUM_REQ*32-1:0] req_a,
  input  logic [NUM_REQ*32-1:0] req_b,
  output logic                  resp_valid,
  input  logic                  resp_ready,
  output logic [ID_W-1:0]       resp_id,
  output logic [31:0]           resp_result,
  output logic                  resp_overflow,
  output logic                  resp_underflow
`ifdef FP_ARB_STATS_EN
  ,
  output logic [31:0]           op_count,
  output logic [31:0]           exc_count
`endif
);
  typedef enum logic [1:0] {
    S_IDLE,
    S_CALC,
    S_RESP
  } state_t;

  state_t           r_state;
  state_t           w_next;
  logic [ID_W-1:0]  r_rr_ptr;
  logic [ID_W-1:0]  r_owner;
  logic [CNT_W-1:0] r_calc_cnt;
  logic [31:0]      r_op_a;
  logic [31:0]      r_op_b;
  logic [ID_W-1:0]  w_gnt;
  logic             w_gnt_vld;
  logic [31:0]      w_sel_a;
  logic [31:0]      w_sel_b;
  logic             w_calc_done;
  logic             w_hs;
  logic [31:0]      w_prod;
  logic             w_ovf;
  logic             w_unf;

  fp_multiplicator u_mul (
    .a   (r_op_a),
    .b   (r_op_b),
    .p   (w_prod),
    .ovf (w_ovf),
    .unf (w_unf)
  );

  // Scan downward so the candidate closest to rr_ptr wins
  always_comb begin
    w_gnt_vld = 1'b0;
    w_gnt     = '0;
    for (int k = NUM_REQ - 1; k >= 0; k--) begin
      if (req_valid[(int'(r_rr_ptr) + k) % NUM_REQ]) begin
        w_gnt_vld = 1'b1;
        w_gnt     = ID_W'((int'(r_rr_ptr) + k) % NUM_REQ);
      end
    end
  end

  always_comb begin
    w_sel_a = '0;
    w_sel_b = '0;
    for (int i = 0; i < NUM_REQ; i++) begin
      if (ID_W'(i) == w_gnt) begin
        w_sel_a = req_a[32*i +: 32];
        w_sel_b = req_b[32*i +: 32];
      end
    end
  end

  assign w_calc_done = (r_state == S_CALC)
                    && (r_calc_cnt == CNT_W'(CALC_CYCLES - 1));
  assign w_hs = (r_state == S_RESP) && resp_ready;

  always_ff @(posedge clk) begin
    if (reset) r_state <= S_IDLE;
    else       r_state <= w_next;
  end

  always_comb begin
    w_next = r_state;
    unique case (r_state)
      S_IDLE: if (w_gnt_vld)   w_next = S_CALC;
      S_CALC: if (w_calc_done) w_next = S_RESP;
      S_RESP: if (resp_ready)  w_next = S_IDLE;
      default:                 w_next = S_IDLE;
    endcase
  end

  always_comb begin
    req_ready  = '0;
    resp_valid = (r_state == S_RESP);
    if ((r_state == S_IDLE) && w_gnt_vld) req_ready[w_gnt] = 1'b1;
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      r_rr_ptr       <= '0;
      r_owner        <= '0;
      r_calc_cnt     <= '0;
      r_op_a         <= '0;
      r_op_b         <= '0;
      resp_id        <= '0;
      resp_result    <= '0;
      resp_overflow  <= 1'b0;
      resp_underflow <= 1'b0;
    end else begin
      if ((r_state == S_IDLE) && w_gnt_vld) begin
        r_op_a     <= w_sel_a;
        r_op_b     <= w_sel_b;
        r_owner    <= w_gnt;
        r_calc_cnt <= '0;
        if (w_gnt == ID_W'(NUM_REQ - 1)) r_rr_ptr <= '0;
        else                             r_rr_ptr <= w_gnt + 1'b1;
      end
      if (r_state == S_CALC) begin
        if (w_calc_done) begin
          resp_result    <= w_prod;
          resp_overflow  <= w_ovf;
          resp_underflow <= w_unf;
          resp_id        <= r_owner;
        end else begin
          r_calc_cnt <= r_calc_cnt + 1'b1;
        end
      end
    end
  end

`ifdef FP_ARB_STATS_EN
  always_ff @(posedge clk) begin
    if (reset) begin
      op_count  <= '0;
      exc_count <= '0;
    end else if (w_hs) begin
      op_count <= op_count + 32'd1;
      if (resp_overflow || resp_underflow) exc_count <= exc_count + 32'd1;
    end
  end
`else
  logic w_unused;
  assign w_unused = w_hs;
`endif
endmodule

// File: tb/tb_fp_mult_arbiter.sv
// Directed + randomized bench for fp_mult_arbiter against a real-arithmetic reference.
// Covers grant order, latency, stall, reset abort and a CALC_CYCLES=3 instance.
module tb_fp_mult_arbiter;
  localparam int CC = 1;

  logic         clk = 1'b0;
  logic         reset;
  logic [3:0]   req_valid, req_ready;
  logic [127:0] req_a, req_b;
  logic         resp_valid, resp_ready;
  logic [1:0]   resp_id;
  logic [31:0]  resp_result;
  logic         resp_overflow, resp_underflow;

  logic [3:0]   req_valid3, req_ready3;
  logic [127:0] req_a3, req_b3;
  logic         resp_valid3, resp_ready3;
  logic [1:0]   resp_id3;
  logic [31:0]  resp_result3;
  logic         resp_overflow3, resp_underflow3;

`ifdef FP_ARB_STATS_EN
  logic [31:0]  op_count, exc_count, op_count3, exc_count3;
`endif

  int checks = 0;
  int errors = 0;
  int cyc = 0;
  int m_ptr = 0;
  int m_ops = 0;
  int m_exc = 0;

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  fp_mult_arbiter #(.NUM_REQ(4), .CALC_CYCLES(CC)) dut (
    .clk(clk), .reset(reset),
    .req_valid(req_valid), .req_ready(req_ready),
    .req_a(req_a), .req_b(req_b),
    .resp_valid(resp_valid), .resp_ready(resp_ready),
    .resp_id(resp_id), .resp_result(resp_result),
    .resp_overflow(resp_overflow), .resp_underflow(resp_underflow)
`ifdef FP_ARB_STATS_EN
    , .op_count(op_count), .exc_count(exc_count)
`endif
  );

  fp_mult_arbiter #(.NUM_REQ(4), .CALC_CYCLES(3)) dut3 (
    .clk(clk), .reset(reset),
    .req_valid(req_valid3), .req_ready(req_ready3),
    .req_a(req_a3), .req_b(req_b3),
    .resp_valid(resp_valid3), .resp_ready(resp_ready3),
    .resp_id(resp_id3), .resp_result(resp_result3),
    .resp_overflow(resp_overflow3), .resp_underflow(resp_underflow3)
`ifdef FP_ARB_STATS_EN
    , .op_count(op_count3), .exc_count(exc_count3)
`endif
  );

  task automatic chk(input string tag, input logic [63:0] obs,
                     input logic [63:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic tmo(input string tag);
    checks++;
    errors++;
    $error("FAIL %s observed timeout expected event", tag);
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  function automatic real fval(input logic [31:0] x);
    return 1.0 + real'(x[22:0]) / 8388608.0;
  endfunction

  // Reference: exact real product, valid for operands whose product needs no rounding
  function automatic logic [33:0] ref_mul(input logic [31:0] a,
                                          input logic [31:0] b);
    logic s;
    real  v;
    int   e;
    logic [22:0] m;
    s = a[31] ^ b[31];
    if (a[30:23] == 0 || b[30:23] == 0) return {2'b00, s, 31'd0};
    v = fval(a) * fval(b);
    e = int'(a[30:23]) + int'(b[30:23]) - 127;
    if (v >= 2.0) begin
      v = v / 2.0;
      e++;
    end
    if (e > 254) return {2'b10, s, 8'hFF, 23'd0};
    if (e < 1)   return {2'b01, s, 31'd0};
    m = 23'(longint'((v - 1.0) * 8388608.0));
    return {2'b00, s, 8'(e), m};
  endfunction

  function automatic int model_grant(input logic [3:0] mask);
    for (int k = 0; k < 4; k++)
      if (mask[(m_ptr + k) % 4]) return (m_ptr + k) % 4;
    return -1;
  endfunction

  task automatic do_op(input string tag, input logic [3:0] mask,
                       input logic [127:0] a, input logic [127:0] b,
                       input bit keep, input int stall, output int g);
    int t;
    int eg;
    bit ok;
    logic [33:0] exp;
    req_valid = mask;
    req_a = a;
    req_b = b;
    resp_ready = 1'b0;
    #1;
    eg = model_grant(mask);
    g = -1;
    ok = 0;
    for (int i = 0; i < 20; i++) begin
      if (|req_ready) begin
        ok = 1;
        break;
      end
      step();
    end
    if (!ok) begin
      tmo({tag, "_grant"});
      return;
    end
    for (int i = 0; i < 4; i++) if (req_ready[i]) g = i;
    t = cyc;
    chk({tag, "_onehot"}, 64'($onehot(req_ready)), 64'd1);
    chk({tag, "_gnt"}, 64'(g), 64'(eg));
    exp = ref_mul(a[32*eg +: 32], b[32*eg +: 32]);
    m_ptr = (eg + 1) % 4;
    step();
    if (!keep) req_valid = '0;
    chk({tag, "_calc_rdy"}, 64'(req_ready), 64'd0);
    ok = 0;
    for (int i = 0; i < 20; i++) begin
      if (resp_valid) begin
        ok = 1;
        break;
      end
      step();
    end
    if (!ok) begin
      tmo({tag, "_resp"});
      return;
    end
    chk({tag, "_lat"}, 64'(cyc - t), 64'(CC + 1));
    for (int s = 0; s <= stall; s++) begin
      chk({tag, "_vld"}, 64'(resp_valid), 64'd1);
      chk({tag, "_res"}, 64'(resp_result), 64'(exp[31:0]));
      chk({tag, "_id"}, 64'(resp_id), 64'(eg));
      chk({tag, "_flg"}, 64'({resp_overflow, resp_underflow}),
          64'(exp[33:32]));
      chk({tag, "_resp_rdy"}, 64'(req_ready), 64'd0);
      if (s < stall) step();
    end
    resp_ready = 1'b1;
    m_ops++;
    if (exp[33] | exp[32]) m_exc++;
    step();
    resp_ready = 1'b0;
    chk({tag, "_done"}, 64'(resp_valid), 64'd0);
`ifdef FP_ARB_STATS_EN
    chk({tag, "_opcnt"}, 64'(op_count), 64'(m_ops));
    chk({tag, "_exccnt"}, 64'(exc_count), 64'(m_exc));
`endif
  endtask

  function automatic logic [31:0] rnd_op();
    logic [31:0] x;
    x[31]    = 1'($urandom_range(0, 1));
    x[30:23] = 8'($urandom_range(100, 154));
    x[22:15] = 8'($urandom_range(0, 255));
    x[14:0]  = '0;
    return x;
  endfunction

  initial begin
    int g;
    int t;
    bit ok;
    logic [127:0] ra, rb;
    int exp_seq[5] = '{0, 1, 2, 3, 0};
    reset = 1'b1;
    req_valid = '0;
    req_a = '0;
    req_b = '0;
    resp_ready = 1'b0;
    req_valid3 = '0;
    req_a3 = '0;
    req_b3 = '0;
    resp_ready3 = 1'b0;
    step();
    step();
    reset = 1'b0;
    #1;
    chk("rst_rdy", 64'(req_ready), 64'd0);
    chk("rst_vld", 64'(resp_valid), 64'd0);
    chk("rst_res", 64'(resp_result), 64'd0);
    chk("rst_id", 64'(resp_id), 64'd0);
    chk("rst_flg", 64'({resp_overflow, resp_underflow}), 64'd0);
`ifdef FP_ARB_STATS_EN
    chk("rst_opcnt", 64'(op_count), 64'd0);
`endif

    do_op("t1", 4'b0001, {96'd0, 32'h4000_0000},
          {96'd0, 32'h4040_0000}, 0, 0, g);
    chk("t1_val", 64'(resp_result), 64'h40C0_0000);

    // Abort an in-flight op from requester 1 with reset
    req_valid = 4'b0010;
    req_a = {64'd0, 32'h4000_0000, 32'd0};
    req_b = {64'd0, 32'h4000_0000, 32'd0};
    #1;
    chk("t5_gnt", 64'(req_ready), 64'h2);
    step();
    req_valid = '0;
    reset = 1'b1;
    step();
    reset = 1'b0;
    m_ptr = 0;
    m_ops = 0;
    m_exc = 0;
    for (int i = 0; i < 4; i++) begin
      chk("t5_novld", 64'(resp_valid), 64'd0);
      step();
    end

    for (int i = 0; i < 5; i++) begin
      do_op("t2", 4'b1111, {4{32'h3FC0_0000}}, {4{32'h3FC0_0000}},
            1, 0, g);
      chk("t2_seq", 64'(g), 64'(exp_seq[i]));
    end
    chk("t2_val", 64'(resp_result), 64'h4010_0000);

    do_op("t3", 4'b0100, {32'd0, 32'h7F00_0000, 64'd0},
          {32'd0, 32'h7F00_0000, 64'd0}, 0, 0, g);
    chk("t3_ovf", 64'(resp_overflow), 64'd1);

    do_op("t4", 4'b1111, {4{32'hC000_0000}}, {4{32'h4040_0000}},
          1, 5, g);
    chk("t4_next", 64'($onehot(req_ready)), 64'd1);

    do_op("unf", 4'b0001, {96'd0, 32'h0080_0000},
          {96'd0, 32'h0080_0000}, 0, 0, g);
    do_op("zero", 4'b0010, {64'd0, 32'h0000_0000, 32'd0},
          {64'd0, 32'h4123_0000, 32'd0}, 0, 0, g);

    for (int n = 0; n < 24; n++) begin
      for (int i = 0; i < 4; i++) begin
        ra[32*i +: 32] = rnd_op();
        rb[32*i +: 32] = rnd_op();
      end
      do_op("rnd", 4'($urandom_range(1, 15)), ra, rb, 0,
            $urandom_range(0, 2), g);
    end

    // Three-cycle compute window on the second instance
    req_valid3 = 4'b1000;
    req_a3 = {32'hC000_0000, 96'd0};
    req_b3 = {32'h4000_0000, 96'd0};
    #1;
    chk("t6_gnt", 64'(req_ready3), 64'h8);
    t = cyc;
    step();
    req_valid3 = '0;
    ok = 0;
    for (int i = 0; i < 20; i++) begin
      if (resp_valid3) begin
        ok = 1;
        break;
      end
      step();
    end
    if (!ok) tmo("t6_resp");
    else begin
      chk("t6_lat", 64'(cyc - t), 64'd4);
      chk("t6_res", 64'(resp_result3), 64'hC080_0000);
      chk("t6_id", 64'(resp_id3), 64'd3);
    end
    resp_ready3 = 1'b1;
    step();
    resp_ready3 = 1'b0;
    req_valid3 = 4'b1001;
    #1;
    chk("t6_wrap", 64'(req_ready3), 64'h1);
    req_valid3 = '0;
    step();

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
